otter_io_timer: RTL and testbench



---
 rtl/otter_io_timer_if.sv | 28 ++
 rtl/otter_io_timer.sv | 230 +++++++++++++++++++++++
 tb/tb_otter_io_timer.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/otter_io_timer_if.sv
// -----------------------------------------------------------------------------
// otter_io_timer_if
// OTTER IOBUS bundle between the MCU (master) and an I/O responder (slave).
//   IOBUS_ADDR [31:0] : byte address driven by the MCU
//   IOBUS_OUT  [31:0] : store data driven by the MCU
//   IOBUS_WR          : one-cycle write strobe per store
//   IOBUS_IN   [31:0] : registered read data returned by the responder
// -----------------------------------------------------------------------------
interface otter_io_timer_if;
  logic [31:0] IOBUS_ADDR;
  logic [31:0] IOBUS_OUT;
  logic        IOBUS_WR;
  logic [31:0] IOBUS_IN;

  modport master (
    output IOBUS_ADDR,
    output IOBUS_OUT,
    output IOBUS_WR,
    input  IOBUS_IN
  );

  modport slave (
    input  IOBUS_ADDR,
    input  IOBUS_OUT,
    input  IOBUS_WR,
    output IOBUS_IN
  );
endinterface

// File: rtl/otter_io_timer.sv
// -----------------------------------------------------------------------------
// otter_io_timer
// IOBUS slave holding the LED register, a synchronized copy of the board
// switches and a prescaled countdown timer whose pending flag drives INTR.
//
// Ports:
//   CLK           : single clock
//   RESET_N       : asynchronous active-low reset
//   bus (slave)   : IOBUS_ADDR / IOBUS_OUT / IOBUS_WR in, IOBUS_IN out (1-cycle)
//   SWITCHES[15:0]: asynchronous switch inputs (2-flop synchronized)
//   LEDS[15:0]    : LED register
//   INTR          : level interrupt = PEND & IE, from a flop
//
// Register window (BASE_ADDR, 32-byte aligned), offset = IOBUS_ADDR[4:2]:
//   0x00 LEDS RW | 0x04 SWITCHES RO | 0x08 TMR_CTRL RW {IE,AUTO,EN}
//   0x0C TMR_LOAD RW | 0x10 TMR_COUNT RO | 0x14 INTR_STAT W1C bit0
//   0x18/0x1C unmapped (read 0, writes dropped)
// -----------------------------------------------------------------------------
module otter_io_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h1100_0000,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic            CLK,
  input  logic            RESET_N,
  otter_io_timer_if.slave bus,
  input  logic [15:0]     SWITCHES,
  output logic [15:0]     LEDS,
  output logic            INTR
);

  // Word offsets inside the register window
  localparam logic [2:0] OFF_LEDS  = 3'd0;
  localparam logic [2:0] OFF_SW    = 3'd1;
  localparam logic [2:0] OFF_CTRL  = 3'd2;
  localparam logic [2:0] OFF_LOAD  = 3'd3;
  localparam logic [2:0] OFF_COUNT = 3'd4;
  localparam logic [2:0] OFF_STAT  = 3'd5;

  // TMR_CTRL bit positions
  localparam int CTRL_EN   = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_IE   = 2;

  // Prescaler counts 0 .. PRESCALE-1; at least one bit wide
  localparam int              PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PS_LAST = PW'(PRESCALE - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [15:0]   leds_q,    leds_d;
  logic [15:0]   sw_meta_q;
  logic [15:0]   sw_sync_q;
  logic [2:0]    ctrl_q,    ctrl_d;
  logic [31:0]   load_q,    load_d;
  logic [31:0]   count_q,   count_d;
  logic          pend_q,    pend_d;
  logic [PW-1:0] presc_q,   presc_d;
  logic [31:0]   rdata_q,   rdata_d;
  logic          intr_q,    intr_d;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic       hit_s;
  logic [2:0] off_s;
  logic       wr_s;
  logic       we_leds_s;
  logic       we_ctrl_s;
  logic       we_load_s;
  logic       we_stat_s;
  logic       tick_s;
  logic       expire_s;
  logic       unused_s;

  // Byte-lane bits are not used by a word-only register file
  assign unused_s = ^bus.IOBUS_ADDR[1:0];

  // Address hit, offset extraction and per-register write enables
  always_comb begin
    hit_s     = (bus.IOBUS_ADDR[31:5] == BASE_ADDR[31:5]);
    off_s     = bus.IOBUS_ADDR[4:2];
    wr_s      = hit_s & bus.IOBUS_WR;
    we_leds_s = wr_s & (off_s == OFF_LEDS);
    we_ctrl_s = wr_s & (off_s == OFF_CTRL);
    we_load_s = wr_s & (off_s == OFF_LOAD);
    we_stat_s = wr_s & (off_s == OFF_STAT);
  end

  // Tick and expiry qualifiers, both from current register state only
  always_comb begin
    tick_s   = ctrl_q[CTRL_EN] & (presc_q == PS_LAST);
    expire_s = tick_s & (count_q == 32'd0);
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------

  // Prescaler: restart on LOAD write, idle at zero while disabled
  always_comb begin
    presc_d = presc_q;
    if (we_load_s) begin
      presc_d = '0;
    end else if (!ctrl_q[CTRL_EN]) begin
      presc_d = '0;
    end else if (tick_s) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  // Counter and reload value; a LOAD write beats any same-cycle tick action
  always_comb begin
    load_d  = load_q;
    count_d = count_q;
    if (we_load_s) begin
      load_d  = bus.IOBUS_OUT;
      count_d = bus.IOBUS_OUT;
    end else if (tick_s) begin
      if (count_q != 32'd0) begin
        count_d = count_q - 32'd1;
      end else if (ctrl_q[CTRL_AUTO]) begin
        count_d = load_q;
      end else begin
        count_d = 32'd0;
      end
    end else begin
      count_d = count_q;
    end
  end

  // Control: a bus write beats the one-shot self-disable on expiry
  always_comb begin
    ctrl_d = ctrl_q;
    if (we_ctrl_s) begin
      ctrl_d = bus.IOBUS_OUT[2:0];
    end else if (expire_s && !ctrl_q[CTRL_AUTO]) begin
      ctrl_d = ctrl_q & 3'b110;
    end else begin
      ctrl_d = ctrl_q;
    end
  end

  // Pending flag: expiry set takes priority over a write-1-to-clear
  always_comb begin
    pend_d = pend_q;
    if (expire_s) begin
      pend_d = 1'b1;
    end else if (we_stat_s && bus.IOBUS_OUT[0]) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end
  end

  // LED register and the registered interrupt level
  always_comb begin
    leds_d = leds_q;
    if (we_leds_s) begin
      leds_d = bus.IOBUS_OUT[15:0];
    end else begin
      leds_d = leds_q;
    end
    // Built from next-state so INTR rises on the same edge as PEND
    intr_d = pend_d & ctrl_d[CTRL_IE];
  end

  // Read mux on pre-write register values; misses and holes return zero
  always_comb begin
    rdata_d = 32'd0;
    if (hit_s) begin
      case (off_s)
        OFF_LEDS:  rdata_d = {16'd0, leds_q};
        OFF_SW:    rdata_d = {16'd0, sw_sync_q};
        OFF_CTRL:  rdata_d = {29'd0, ctrl_q};
        OFF_LOAD:  rdata_d = load_q;
        OFF_COUNT: rdata_d = count_q;
        OFF_STAT:  rdata_d = {31'd0, pend_q};
        default:   rdata_d = 32'd0;
      endcase
    end else begin
      rdata_d = 32'd0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------

  // Two-flop synchronizer for the asynchronous switch inputs
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sw_meta_q <= 16'd0;
      sw_sync_q <= 16'd0;
    end else begin
      sw_meta_q <= SWITCHES;
      sw_sync_q <= sw_meta_q;
    end
  end

  // Architectural registers, timer state and registered outputs
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      leds_q  <= 16'd0;
      ctrl_q  <= 3'd0;
      load_q  <= 32'd0;
      count_q <= 32'd0;
      pend_q  <= 1'b0;
      presc_q <= '0;
      rdata_q <= 32'd0;
      intr_q  <= 1'b0;
    end else begin
      leds_q  <= leds_d;
      ctrl_q  <= ctrl_d;
      load_q  <= load_d;
      count_q <= count_d;
      pend_q  <= pend_d;
      presc_q <= presc_d;
      rdata_q <= rdata_d;
      intr_q  <= intr_d;
    end
  end

  assign LEDS         = leds_q;
  assign INTR         = intr_q;
  assign bus.IOBUS_IN = rdata_q;

endmodule

// File: tb/tb_otter_io_timer.sv
// -----------------------------------------------------------------------------
// tb_otter_io_timer
// Self-checking bench for otter_io_timer (PRESCALE = 1). Bus reads push their
// expected data into a scoreboard queue; the value is popped and compared when
// IOBUS_IN becomes valid one edge later. Inputs change and outputs are sampled
// 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_otter_io_timer;

  localparam logic [31:0] BASE  = 32'h1100_0000;
  localparam logic [31:0] A_LED = BASE + 32'h00;
  localparam logic [31:0] A_SW  = BASE + 32'h04;
  localparam logic [31:0] A_CTL = BASE + 32'h08;
  localparam logic [31:0] A_LD  = BASE + 32'h0C;
  localparam logic [31:0] A_CNT = BASE + 32'h10;
  localparam logic [31:0] A_ST  = BASE + 32'h14;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [15:0] SWITCHES;
  logic [15:0] LEDS;
  logic        INTR;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  otter_io_timer_if bus();

  otter_io_timer #(.BASE_ADDR(BASE), .PRESCALE(1)) dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .bus      (bus),
    .SWITCHES (SWITCHES),
    .LEDS     (LEDS),
    .INTR     (INTR)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.IOBUS_ADDR = a;
    bus.IOBUS_OUT  = d;
    bus.IOBUS_WR   = 1'b1;
    step();
    bus.IOBUS_WR   = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string n);
    bus.IOBUS_ADDR = a;
    bus.IOBUS_WR   = 1'b0;
    exp_q.push_back(e);
    name_q.push_back(n);
    step();
  endtask

  task automatic sb_pop(output logic [31:0] e, output string n);
    if (exp_q.size() == 0) begin
      e = 32'hxxxx_xxxx;
      n = "sb_underflow";
    end else begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
    end
  endtask

  task automatic test_reset();
    logic [31:0] e;
    string n;
    RESET_N = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.IOBUS_ADDR = BASE | (32'($urandom_range(0, 7)) << 2);
      bus.IOBUS_OUT  = $urandom;
      bus.IOBUS_WR   = 1'($urandom_range(0, 1));
      SWITCHES       = 16'($urandom);
      step();
      checks++;
      if ({LEDS, INTR} !== 17'd0) begin
        errors++;
        $display("FAIL reset_outputs got leds=%h intr=%b want leds=0000 intr=0", LEDS, INTR);
      end
      checks++;
      if (bus.IOBUS_IN !== 32'd0) begin
        errors++;
        $display("FAIL reset_iobus_in got %h want 00000000", bus.IOBUS_IN);
      end
    end
    bus.IOBUS_WR   = 1'b0;
    bus.IOBUS_ADDR = A_LED;
    SWITCHES       = 16'h0000;
    RESET_N        = 1'b1;
    rd(A_CTL, 32'd0, "ctrl_after_reset");
    sb_pop(e, n); checks++;
    if (bus.IOBUS_IN !== e) begin errors++; $display("FAIL %s got %h want %h", n, bus.IOBUS_IN, e); end
    rd(A_LD, 32'd0, "load_after_reset");
    sb_pop(e, n); checks++;
    if (bus.IOBUS_IN !== e) begin errors++; $display("FAIL %s got %h want %h", n, bus.IOBUS_IN, e); end
    rd(A_CNT, 32'd0, "count_after_reset");
    sb_pop(e, n); checks++;
    if (bus.IOBUS_IN !== e) begin errors++; $display("FAIL %s got %h want %h", n, bus.IOBUS_IN, e); end
  endtask

  task automatic test_leds_switches();
    logic [31:0] e;
    string n;
    // Reading and writing the same address returns the old value
    exp_q.push_back(32'd0);
    name_q.push_back("led_same_cycle_old");
    wr(A_LED, 32'h1234_ABCD);
    sb_pop(e, n); checks++;
    if (bus.IOBUS_IN !== e) begin errors++; $display("FAIL %s got %h want %h", n, bus.IOBUS_IN, e); end
    checks++;
    if (LEDS !== 16'hABCD) begin errors++; $display("FAIL leds_port got %h want abcd", LEDS); end
    rd(A_LED, 32'h0000_ABCD, "led_readback");
    sb_pop(e, n); checks++;
    if (bus.IOBUS_IN !== e) begin errors++; $display("FAIL %s got %h want %h", n, bus.IOBUS_IN, e); end
    SWITCHES = 16'h00F0;
    rd(A_SW, 32'd0, "sw_edge1");
    sb_pop(e, n); checks++;
    if (bus.IOBUS_IN !== e) begin errors++; $display("FAIL %s got %h want %h", n, bus.IOBUS_IN, e); end
    rd(A_SW, 32'd0, "sw_edge2");
    sb_pop(e, n); checks++;
    if (bus.IOBUS_IN !== e) begin errors++; $display("FAIL %s got %h want %h", n, bus.IOBUS_IN, e); end
    rd(A_SW, 32'h0000_00F0, "sw_edge3");
    sb_pop(e, n); checks++;
    if (bus.IOBUS_IN !== e) begin errors++; $display("FAIL %s got %h want %h", n, bus.IOBUS_IN, e); end
  endtask

  task automatic test_one_shot();
    logic [31:0] e;
    string n;
    wr(A_LD, 32'd3);
    wr(A_CTL, 32'h5);
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++;
      if (INTR !== (i == 4)) begin
        errors++;
        $display("FAIL oneshot_intr_edge%0d got %b want %b", i, INTR, (i == 4));
      end
    end
    rd(A_CTL, 32'h4, "oneshot_en_cleared");
    sb_pop(e, n); checks++;
    if (bus.IOBUS_IN !== e) begin errors++; $display("FAIL %s got %h want %h", n, bus.IOBUS_IN, e); end
    rd(A_CNT, 32'd0, "oneshot_count_zero");
    sb_pop(e, n); checks++;
    if (bus.IOBUS_IN !== e) begin errors++; $display("FAIL %s got %h want %h", n, bus.IOBUS_IN, e); end
    wr(A_ST, 32'h1);
    checks++;
    if (INTR !== 1'b0) begin errors++; $display("FAIL oneshot_w1c_intr got %b want 0", INTR); end
    rd(A_ST, 32'd0, "oneshot_pend_cleared");
    sb_pop(e, n); checks++;
    if (bus.IOBUS_IN !== e) begin errors++; $display("FAIL %s got %h want %h", n, bus.IOBUS_IN, e); end
    // CTRL write colliding with a one-shot expiry keeps the written EN
    wr(A_LD, 32'd0);
    wr(A_CTL, 32'h1);
    wr(A_CTL, 32'h1);
    rd(A_CTL, 32'h1, "ctrl_write_beats_expiry");
    sb_pop(e, n); checks++;
    if (bus.IOBUS_IN !== e) begin errors++; $display("FAIL %s got %h want %h", n, bus.IOBUS_IN, e); end
    rd(A_CTL, 32'h0, "ctrl_then_self_disable");
    sb_pop(e, n); checks++;
    if (bus.IOBUS_IN !== e) begin errors++; $display("FAIL %s got %h want %h", n, bus.IOBUS_IN, e); end
    wr(A_ST, 32'h1);
  endtask

  task automatic test_auto_collision();
    logic [31:0] e;
    string n;
    wr(A_LD, 32'd0);
    wr(A_CTL, 32'h7);
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++;
      if (INTR !== 1'b1) begin errors++; $display("FAIL auto_intr_cycle%0d got %b want 1", i, INTR); end
    end
    wr(A_ST, 32'h1);
    checks++;
    if (INTR !== 1'b1) begin errors++; $display("FAIL set_beats_clear_intr got %b want 1", INTR); end
    rd(A_ST, 32'h1, "set_beats_clear_pend");
    sb_pop(e, n); checks++;
    if (bus.IOBUS_IN !== e) begin errors++; $display("FAIL %s got %h want %h", n, bus.IOBUS_IN, e); end
    rd(A_CNT, 32'd0, "auto_count_zero");
    sb_pop(e, n); checks++;
    if (bus.IOBUS_IN !== e) begin errors++; $display("FAIL %s got %h want %h", n, bus.IOBUS_IN, e); end
    wr(A_CTL, 32'h0);
    checks++;
    if (INTR !== 1'b0) begin errors++; $display("FAIL ie_off_intr got %b want 0", INTR); end
    wr(A_ST, 32'h0);
    rd(A_ST, 32'h1, "w0_no_effect");
    sb_pop(e, n); checks++;
    if (bus.IOBUS_IN !== e) begin errors++; $display("FAIL %s got %h want %h", n, bus.IOBUS_IN, e); end
    wr(A_ST, 32'h1);
    rd(A_ST, 32'h0, "w1c_clears");
    sb_pop(e, n); checks++;
    if (bus.IOBUS_IN !== e) begin errors++; $display("FAIL %s got %h want %h", n, bus.IOBUS_IN, e); end
  endtask

  task automatic test_decode();
    logic [31:0] e;
    string n;
    wr(BASE + 32'h18, 32'hFFFF_FFFF);
    wr(BASE + 32'h1C, 32'hFFFF_FFFF);
    wr(BASE + 32'h20, 32'hFFFF_FFFF);
    wr(A_SW, 32'hFFFF_FFFF);
    checks++;
    if (LEDS !== 16'hABCD) begin errors++; $display("FAIL decode_leds_kept got %h want abcd", LEDS); end
    rd(BASE + 32'h18, 32'd0, "hole_reads_zero");
    sb_pop(e, n); checks++;
    if (bus.IOBUS_IN !== e) begin errors++; $display("FAIL %s got %h want %h", n, bus.IOBUS_IN, e); end
    rd(BASE + 32'h20, 32'd0, "miss_reads_zero");
    sb_pop(e, n); checks++;
    if (bus.IOBUS_IN !== e) begin errors++; $display("FAIL %s got %h want %h", n, bus.IOBUS_IN, e); end
    rd(A_CTL, 32'd0, "decode_ctrl_kept");
    sb_pop(e, n); checks++;
    if (bus.IOBUS_IN !== e) begin errors++; $display("FAIL %s got %h want %h", n, bus.IOBUS_IN, e); end
    rd(A_SW, 32'h0000_00F0, "sw_ro_kept");
    sb_pop(e, n); checks++;
    if (bus.IOBUS_IN !== e) begin errors++; $display("FAIL %s got %h want %h", n, bus.IOBUS_IN, e); end
    rd(BASE + 32'h3, 32'h0000_ABCD, "byte_bits_ignored");
    sb_pop(e, n); checks++;
    if (bus.IOBUS_IN !== e) begin errors++; $display("FAIL %s got %h want %h", n, bus.IOBUS_IN, e); end
    wr(A_LD, 32'h55);
    wr(A_CNT, 32'hDEAD_BEEF);
    rd(A_CNT, 32'h55, "count_ro_kept");
    sb_pop(e, n); checks++;
    if (bus.IOBUS_IN !== e) begin errors++; $display("FAIL %s got %h want %h", n, bus.IOBUS_IN, e); end
  endtask

  task automatic test_async_reset();
    logic [31:0] e;
    string n;
    // Leave PEND set with IE so INTR is high going into the reset pulse
    wr(A_LD, 32'd0);
    wr(A_CTL, 32'h5);
    step();
    wr(A_LD, 32'd100);
    wr(A_CTL, 32'h5);
    repeat (50) step();
    checks++;
    if (dut.count_q !== 32'd50) begin errors++; $display("FAIL midcount_value got %0d want 50", dut.count_q); end
    checks++;
    if (INTR !== 1'b1) begin errors++; $display("FAIL midcount_intr got %b want 1", INTR); end
    #2;
    RESET_N = 1'b0;
    #1;
    checks++;
    if (dut.count_q !== 32'd0) begin errors++; $display("FAIL async_count got %h want 0", dut.count_q); end
    checks++;
    if (dut.ctrl_q !== 3'd0) begin errors++; $display("FAIL async_ctrl got %h want 0", dut.ctrl_q); end
    checks++;
    if ({INTR, LEDS, bus.IOBUS_IN} !== 49'd0) begin
      errors++;
      $display("FAIL async_outputs got intr=%b leds=%h in=%h want 0", INTR, LEDS, bus.IOBUS_IN);
    end
    #1;
    RESET_N = 1'b1;
    wr(A_LED, 32'h0000_0042);
    checks++;
    if (LEDS !== 16'h0042) begin errors++; $display("FAIL first_write_after_reset got %h want 0042", LEDS); end
    rd(A_CNT, 32'd0, "count_after_async");
    sb_pop(e, n); checks++;
    if (bus.IOBUS_IN !== e) begin errors++; $display("FAIL %s got %h want %h", n, bus.IOBUS_IN, e); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET_N        = 1'b0;
    bus.IOBUS_ADDR = 32'd0;
    bus.IOBUS_OUT  = 32'd0;
    bus.IOBUS_WR   = 1'b0;
    SWITCHES       = 16'd0;
    test_reset();
    test_leds_switches();
    test_one_shot();
    test_auto_collision();
    test_decode();
    test_async_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
